// File: rtl/pcs_tx_pkg.sv
// Shared PCS TX definitions: XGMII control characters, read-side scheduler
// states and the gray/binary pointer helper used by both FIFO domains.
package pcs_tx_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;

  // Widest pointer the helper handles; callers zero-extend and truncate back.
  localparam int PTR_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_IFG    = 2'd3
  } rd_state_e;

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/tx_fifo_rd_ctrl_if.sv
// Read-side bundle: FIFO head/pointers toward the scheduler and the column
// stream toward the TX encoder.
interface tx_fifo_rd_ctrl_if #(
  parameter int ADDRSIZE = 3,
  parameter int DATA_W   = 32
);
  localparam int CTRL_W = DATA_W / 8;

  logic [ADDRSIZE:0]          rptr;
  logic [ADDRSIZE:0]          rq2_wptr;
  logic                       rempty;
  logic [DATA_W+CTRL_W-1:0]   rdata;
  logic                       rinc;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [CTRL_W-1:0]          out_ctrl;

  modport master (
    input  rptr, rq2_wptr, rempty, rdata, out_ready,
    output rinc, out_data, out_ctrl
  );

  modport slave (
    output rptr, rq2_wptr, rempty, rdata, out_ready,
    input  rinc, out_data, out_ctrl
  );

endinterface

// File: rtl/fifo_level_calc.sv
// FIFO occupancy from two gray pointers; modulo arithmetic keeps it correct
// across pointer wrap.
module fifo_level_calc
  import pcs_tx_pkg::*;
#(
  parameter int ADDRSIZE = 3
) (
  input  logic [ADDRSIZE:0] rptr_i,
  input  logic [ADDRSIZE:0] wptr_i,
  output logic [ADDRSIZE:0] level_o
);

  localparam int PW = ADDRSIZE + 1;

  assign level_o = PW'(gray2bin(PTR_MAX_W'(wptr_i)) - gray2bin(PTR_MAX_W'(rptr_i)));

endmodule

// File: rtl/tx_fifo_rd_ctrl.sv
// PCS TX FIFO read scheduler: holds a frame until START_THRESH columns are
// buffered, streams it, pads MIN_IFG idles, and converts underrun to error+flush.
module tx_fifo_rd_ctrl
  import pcs_tx_pkg::*;
#(
  parameter int ADDRSIZE     = 3,
  parameter int DATA_W       = 32,
  parameter int START_THRESH = 4,
  parameter int MIN_IFG      = 2
) (
  input  logic                 rclk,
  input  logic                 rrst,
  tx_fifo_rd_ctrl_if.master    bus,
  output logic [ADDRSIZE:0]    level,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           underrun_cnt
);

  localparam int CTRL_W = DATA_W / 8;

  localparam logic [DATA_W-1:0]  IDLE_DATA = {CTRL_W{XGMII_IDLE}};
  localparam logic [DATA_W-1:0]  ERR_DATA  = {CTRL_W{XGMII_ERR}};
  localparam logic [CTRL_W-1:0]  CTRL_ALL  = {CTRL_W{1'b1}};
  localparam logic [ADDRSIZE:0]  THRESH    = (ADDRSIZE+1)'(START_THRESH);
  localparam logic [3:0]         IFG_INIT  = 4'(MIN_IFG);
  localparam rd_state_e          POST_TERM = (MIN_IFG > 0) ? ST_IFG : ST_IDLE;

  rd_state_e          state_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [CTRL_W-1:0]  out_ctrl_q;
  logic [15:0]        frame_cnt_q;
  logic [7:0]         underrun_cnt_q;
  logic [7:0]         underrun_cnt_d;
  logic [3:0]         ifg_cnt_q;

  logic [DATA_W-1:0]  head_data;
  logic [CTRL_W-1:0]  head_ctrl;
  logic [CTRL_W-1:0]  term_lane;
  logic               head_is_term;

  fifo_level_calc #(.ADDRSIZE(ADDRSIZE)) u_level (
    .rptr_i  (bus.rptr),
    .wptr_i  (bus.rq2_wptr),
    .level_o (level)
  );

  assign head_data = bus.rdata[DATA_W-1:0];
  assign head_ctrl = bus.rdata[DATA_W+CTRL_W-1:DATA_W];

  for (genvar i = 0; i < CTRL_W; i++) begin : g_lane
    assign term_lane[i] = head_ctrl[i] && (head_data[8*i +: 8] == XGMII_TERM);
  end
  assign head_is_term = |term_lane;

  assign underrun_cnt_d = (underrun_cnt_q == 8'hFF) ? underrun_cnt_q : underrun_cnt_q + 8'd1;

  // Pops only while a frame is being forwarded or flushed; never on empty.
  assign bus.rinc = bus.out_ready && !bus.rempty &&
                    ((state_q == ST_STREAM) || (state_q == ST_FLUSH));

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q        <= ST_IDLE;
      out_data_q     <= IDLE_DATA;
      out_ctrl_q     <= CTRL_ALL;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
      ifg_cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.out_ready) begin
            out_data_q <= IDLE_DATA;
            out_ctrl_q <= CTRL_ALL;
          end
          // Start decision ignores out_ready so a stalled encoder cannot hide occupancy.
          if (level >= THRESH) state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          if (bus.out_ready) begin
            if (!bus.rempty) begin
              out_data_q <= head_data;
              out_ctrl_q <= head_ctrl;
              if (head_is_term) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                ifg_cnt_q   <= IFG_INIT;
                state_q     <= POST_TERM;
              end
            end else begin
              out_data_q     <= ERR_DATA;
              out_ctrl_q     <= CTRL_ALL;
              underrun_cnt_q <= underrun_cnt_d;
              state_q        <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Remainder of a broken frame is discarded up to its terminate column.
          if (bus.out_ready) begin
            out_data_q <= IDLE_DATA;
            out_ctrl_q <= CTRL_ALL;
            if (!bus.rempty && head_is_term) begin
              ifg_cnt_q <= IFG_INIT;
              state_q   <= POST_TERM;
            end
          end
        end
        ST_IFG: begin
          if (bus.out_ready) begin
            out_data_q <= IDLE_DATA;
            out_ctrl_q <= CTRL_ALL;
            ifg_cnt_q  <= ifg_cnt_q - 4'd1;
            if (ifg_cnt_q <= 4'd1) state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_ctrl = out_ctrl_q;
  assign frame_cnt    = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_tx_fifo_rd_ctrl.sv
// Bench for tx_fifo_rd_ctrl: a queue-level FIFO model feeds the DUT and the
// emitted column stream is compared against frame contents built here.
module tb_tx_fifo_rd_ctrl;
  localparam int ADDRSIZE = 3, DATA_W = 32, START_THRESH = 4, MIN_IFG = 2;

  typedef logic [35:0] col_t;
  typedef col_t col_q_t[$];
  localparam col_t IDLE_COL = 36'hF_0707_0707;
  localparam col_t ERR_COL  = 36'hF_FEFE_FEFE;

  logic rclk, rrst;
  logic [ADDRSIZE:0] level;
  logic [15:0] frame_cnt;
  logic [7:0] underrun_cnt;

  tx_fifo_rd_ctrl_if #(.ADDRSIZE(ADDRSIZE), .DATA_W(DATA_W)) bus ();

  tx_fifo_rd_ctrl #(.ADDRSIZE(ADDRSIZE), .DATA_W(DATA_W), .START_THRESH(START_THRESH),
                    .MIN_IFG(MIN_IFG)) dut (
    .rclk(rclk), .rrst(rrst), .bus(bus), .level(level),
    .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt));

  col_t mem [8];
  logic [3:0] wbin, rbin, load_val;
  logic load_req, clr_run;
  int checks, errors, exp_frames, exp_under, cur_run, max_run;
  col_q_t out_log;

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  assign bus.rq2_wptr = wbin ^ (wbin >> 1);
  assign bus.rptr     = rbin ^ (rbin >> 1);
  assign bus.rempty   = (wbin == rbin);
  assign bus.rdata    = mem[rbin[2:0]];

  // Read pointer shares the scheduler's reset; load_req lets a test park it anywhere.
  always @(posedge rclk) begin
    if (load_req) rbin <= load_val;
    else if (rrst) rbin <= '0;
    else if (bus.rinc) rbin <= rbin + 4'd1;
  end

  always @(posedge rclk) begin
    if (clr_run) begin
      cur_run <= 0; max_run <= 0;
    end else begin
      cur_run <= bus.rinc ? cur_run + 1 : 0;
      if (bus.rinc && cur_run + 1 > max_run) max_run <= cur_run + 1;
    end
  end

  always @(posedge rclk) begin
    if (!rrst && bus.out_ready) begin
      #1 out_log.push_back({bus.out_ctrl, bus.out_data});
    end
  end

  always @(negedge rclk) begin
    if (!rrst) begin
      checks++;
      if (bus.rinc && bus.rempty) begin
        errors++; $display("FAIL rinc_on_empty: rinc=%b rempty=%b required no pop", bus.rinc, bus.rempty);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic push_word(input col_t w);
    mem[wbin[2:0]] = w;
    wbin = wbin + 4'd1;
  endtask

  task automatic drain(input int n);
    bus.out_ready = 1'b1;
    cyc(n);
  endtask

  function automatic col_q_t make_frame(input int len);
    col_q_t f;
    for (int i = 0; i < len; i++) begin
      if (i == 0)            f.push_back({4'h1, 24'($urandom), 8'hFB});
      else if (i == len - 1) f.push_back({4'h1, 24'($urandom), 8'hFD});
      else                   f.push_back({4'h0, 32'($urandom)});
    end
    return f;
  endfunction

  function automatic col_q_t non_idle(input col_q_t q);
    col_q_t r;
    foreach (q[i]) if (q[i] != IDLE_COL) r.push_back(q[i]);
    return r;
  endfunction

  task automatic new_scenario();
    clr_run = 1'b1;
    @(negedge rclk);
    clr_run = 1'b0;
    out_log.delete();
  endtask

  task automatic test_reset();
    rrst = 1'b1; bus.out_ready = 1'b1; wbin = '0;
    cyc(2);
    checks += 6;
    if (bus.out_data !== 32'h0707_0707) begin errors++; $display("FAIL reset_data: got %h need 07070707", bus.out_data); end
    if (bus.out_ctrl !== 4'hF) begin errors++; $display("FAIL reset_ctrl: got %h need f", bus.out_ctrl); end
    if (bus.rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b need 0", bus.rinc); end
    if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d need 0", frame_cnt); end
    if (underrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_underruns: got %0d need 0", underrun_cnt); end
    if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d need 0", level); end
    rrst = 1'b0; exp_frames = 0; exp_under = 0;
    cyc(1);
  endtask

  task automatic test_threshold();
    col_q_t f, got;
    new_scenario();
    f = make_frame(5);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_word(f[k]);
      #1;
      checks += 2;
      if (level !== 4'(k + 1)) begin errors++; $display("FAIL thresh_level: got %0d need %0d", level, k + 1); end
      if (bus.rinc !== 1'b0) begin errors++; $display("FAIL thresh_early_pop: got %b need 0", bus.rinc); end
      @(negedge rclk);
    end
    checks++;
    if (bus.rinc !== 1'b1) begin errors++; $display("FAIL thresh_start: rinc got %b need 1", bus.rinc); end
    push_word(f[4]);
    drain(15);
    exp_frames++;
    got = non_idle(out_log);
    checks += 3;
    if (max_run != 5) begin errors++; $display("FAIL thresh_pop_run: got %0d need 5", max_run); end
    if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL thresh_frames: got %0d need %0d", frame_cnt, exp_frames); end
    if (got.size() != f.size()) begin errors++; $display("FAIL thresh_cols: got %0d need %0d", got.size(), f.size()); end
    for (int i = 0; i < f.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== f[i]) begin errors++; $display("FAIL thresh_col%0d: got %h need %h", i, got[i], f[i]); end
    end
  endtask

  task automatic test_back_to_back();
    col_q_t a, b, exp;
    int p;
    new_scenario();
    a = make_frame(4); b = make_frame(4);
    foreach (a[i]) push_word(a[i]);
    foreach (b[i]) push_word(b[i]);
    drain(30);
    exp_frames += 2;
    // Between frames: MIN_IFG idles, then one idle while IDLE sees the threshold.
    exp = a;
    for (int i = 0; i < MIN_IFG + 1; i++) exp.push_back(IDLE_COL);
    foreach (b[i]) exp.push_back(b[i]);
    p = -1;
    foreach (out_log[i]) if (p < 0 && out_log[i] == a[0]) p = i;
    checks++;
    if (p < 0) begin errors++; $display("FAIL b2b_start: first column %h never emitted", a[0]); p = 0; end
    foreach (exp[i]) begin
      col_t g;
      g = (p + i < out_log.size()) ? out_log[p + i] : 'x;
      checks++;
      if (g !== exp[i]) begin errors++; $display("FAIL b2b_col%0d: got %h need %h", i, g, exp[i]); end
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL b2b_frames: got %0d need %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_underrun();
    col_q_t f, g, got, exp;
    new_scenario();
    f = make_frame(6); g = make_frame(4);
    for (int i = 0; i < 4; i++) push_word(f[i]);
    drain(12);
    exp_under++;
    checks += 2;
    if (underrun_cnt !== 8'(exp_under)) begin errors++; $display("FAIL underrun_cnt: got %0d need %0d", underrun_cnt, exp_under); end
    if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL underrun_frames: got %0d need %0d", frame_cnt, exp_frames); end
    push_word(f[4]); push_word(f[5]);
    foreach (g[i]) push_word(g[i]);
    drain(20);
    exp_frames++;
    for (int i = 0; i < 4; i++) exp.push_back(f[i]);
    exp.push_back(ERR_COL);
    foreach (g[i]) exp.push_back(g[i]);
    got = non_idle(out_log);
    checks += 3;
    if (rbin !== wbin) begin errors++; $display("FAIL underrun_discard: rptr %0d need %0d", rbin, wbin); end
    if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL underrun_frames2: got %0d need %0d", frame_cnt, exp_frames); end
    if (got.size() != exp.size()) begin errors++; $display("FAIL underrun_cols: got %0d need %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL underrun_col%0d: got %h need %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    col_q_t f, got;
    logic [3:0] start;
    logic [35:0] hold;
    int c;
    new_scenario();
    f = make_frame(6);
    start = rbin;
    foreach (f[i]) push_word(f[i]);
    bus.out_ready = 1'b1;
    for (c = 0; c < 20 && 4'(rbin - start) < 4'd2; c++) @(negedge rclk);
    checks++;
    if (c >= 20) begin errors++; $display("FAIL bp_timeout: popped %0d need 2", 4'(rbin - start)); end
    bus.out_ready = 1'b0;
    hold = {bus.out_ctrl, bus.out_data};
    repeat (3) begin
      @(negedge rclk);
      checks += 2;
      if (bus.rinc !== 1'b0) begin errors++; $display("FAIL bp_rinc: got %b need 0", bus.rinc); end
      if ({bus.out_ctrl, bus.out_data} !== hold) begin
        errors++; $display("FAIL bp_hold: got %h need %h", {bus.out_ctrl, bus.out_data}, hold);
      end
    end
    drain(20);
    exp_frames++;
    got = non_idle(out_log);
    checks += 2;
    if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL bp_frames: got %0d need %0d", frame_cnt, exp_frames); end
    if (got.size() != f.size()) begin errors++; $display("FAIL bp_cols: got %0d need %0d", got.size(), f.size()); end
    for (int i = 0; i < f.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== f[i]) begin errors++; $display("FAIL bp_col%0d: got %h need %h", i, got[i], f[i]); end
    end
  endtask

  task automatic test_wrap();
    col_q_t f, got;
    // Reset drops counters and parks both pointers at binary 13.
    rrst = 1'b1; load_val = 4'd13; load_req = 1'b1; wbin = 4'd13;
    @(negedge rclk);
    rrst = 1'b0; load_req = 1'b0;
    exp_frames = 0; exp_under = 0;
    new_scenario();
    f = make_frame(4);
    foreach (f[i]) push_word(f[i]);
    #1;
    checks += 2;
    if (wbin !== 4'd1) begin errors++; $display("FAIL wrap_setup: wptr %0d need 1", wbin); end
    if (level !== 4'd4) begin errors++; $display("FAIL wrap_level: got %0d need 4", level); end
    @(negedge rclk);
    checks++;
    if (bus.rinc !== 1'b1) begin errors++; $display("FAIL wrap_start: rinc got %b need 1", bus.rinc); end
    drain(15);
    exp_frames++;
    got = non_idle(out_log);
    checks += 2;
    if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL wrap_frames: got %0d need %0d", frame_cnt, exp_frames); end
    if (got.size() != f.size()) begin errors++; $display("FAIL wrap_cols: got %0d need %0d", got.size(), f.size()); end
    for (int i = 0; i < f.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== f[i]) begin errors++; $display("FAIL wrap_col%0d: got %h need %h", i, got[i], f[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      col_q_t f, got;
      int density, c;
      new_scenario();
      f = make_frame($urandom_range(4, 8));
      density = $urandom_range(40, 100);
      foreach (f[i]) push_word(f[i]);
      for (c = 0; c < 200 && rbin != wbin; c++) begin
        bus.out_ready = ($urandom_range(1, 100) <= density);
        @(negedge rclk);
      end
      drain(6);
      exp_frames++;
      got = non_idle(out_log);
      checks += 4;
      if (c >= 200) begin errors++; $display("FAIL rand%0d_timeout: %0d words left", it, 4'(wbin - rbin)); end
      if (frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL rand%0d_frames: got %0d need %0d", it, frame_cnt, exp_frames); end
      if (underrun_cnt !== 8'(exp_under)) begin errors++; $display("FAIL rand%0d_underruns: got %0d need %0d", it, underrun_cnt, exp_under); end
      if (got.size() != f.size()) begin errors++; $display("FAIL rand%0d_cols: got %0d need %0d", it, got.size(), f.size()); end
      for (int i = 0; i < f.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== f[i]) begin errors++; $display("FAIL rand%0d_col%0d: got %h need %h", it, i, got[i], f[i]); end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; exp_frames = 0; exp_under = 0;
    rrst = 1'b1; load_req = 1'b0; load_val = '0; clr_run = 1'b0;
    wbin = '0; bus.out_ready = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    test_reset();
    test_threshold();
    test_back_to_back();
    test_underrun();
    test_backpressure();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_fifo_rd_ctrl.md
Name: tx_fifo_rd_ctrl

Overview:
Read-side scheduler for the PCS TX async FIFO. It lives in the read clock domain next to the read-pointer/empty logic and decides when to pop (rinc). It forwards buffered XGMII-style frame columns to the TX encoder and fills gaps with idle columns. It holds each frame until enough columns are buffered, enforces a minimum inter-frame gap, and turns a mid-frame FIFO underrun into an error column followed by a flush to the end of the frame.

Parameters:
ADDRSIZE, 3, FIFO address width; pointers are ADDRSIZE+1 bits, depth 2**ADDRSIZE
DATA_W, 32, column data width; CTRL_W = DATA_W/8 lanes, one ctrl bit per byte
START_THRESH, 4, minimum FIFO occupancy before a frame starts streaming (1..2**ADDRSIZE)
MIN_IFG, 2, idle columns forced after each frame's terminate column (0..15)

Ports:
rclk  in  1  read-domain clock; only clock in the block
rrst  in  1  reset, synchronous, active-high
rptr  in  ADDRSIZE+1  gray read pointer from the read-pointer logic
rq2_wptr  in  ADDRSIZE+1  gray write pointer, already synchronized into rclk
rempty  in  1  FIFO empty flag (registered)
rdata  in  DATA_W+CTRL_W  FIFO head word {ctrl, data}, valid while !rempty
rinc  out  1  pop strobe to the FIFO
out_ready  in  1  encoder accepts a column this cycle
out_data  out  DATA_W  column data to encoder
out_ctrl  out  CTRL_W  column ctrl bits
level  out  ADDRSIZE+1  FIFO occupancy
frame_cnt  out  16  frames completed; wraps
underrun_cnt  out  8  underrun events; saturates at 255

Behaviour:
- Reset: state IDLE; out_data = 0x07 in every byte (0x07070707); out_ctrl = all ones; frame_cnt = 0; underrun_cnt = 0; IFG counter = 0. rrst and the FIFO read-side reset are driven from the same event (rrst_n = ~rrst) so pointers and state stay coherent. A mid-operation reset drops any frame in progress.
- level = gray2bin(rq2_wptr) - gray2bin(rptr), modulo 2**(ADDRSIZE+1). This stays correct across pointer wrap. Combinational, registered nowhere.
- rinc = out_ready & ~rempty & (state==STREAM | state==FLUSH). Combinational. rinc is never asserted while rempty is high.
- Outputs are registered and update only on out_ready cycles; when out_ready=0 they hold.
- Terminate detect on rdata: some lane i has ctrl[i]=1 and byte i = 0xFD.
- IDLE: each out_ready cycle emits an idle column. When level >= START_THRESH, go to STREAM on the next cycle; this check does not depend on out_ready. No pop happens in the transition cycle.
- STREAM, out_ready & ~rempty: out <= rdata and pop.
  - If the popped word contains a terminate: frame_cnt++.
  - Then, if MIN_IFG > 0, go to IFG with counter = MIN_IFG; otherwise go to IDLE.
- STREAM, out_ready & rempty (underrun): emit the error column (data = 0xFE in all bytes, ctrl = all ones), underrun_cnt++ (saturating), go to FLUSH.
- FLUSH: each out_ready cycle emits an idle column. Words are popped and discarded while ~rempty. A discarded word containing a terminate moves to IFG/IDLE under the same rule as STREAM; frame_cnt is not incremented.
- IFG: each out_ready cycle emits an idle and decrements the counter. Reaching 0 goes to IDLE, so exactly MIN_IFG idles are emitted after the terminate column.
- The FIFO carries frame columns only; idle columns are never written into it.
- State encoding is 2-bit: IDLE=0, STREAM=1, FLUSH=2, IFG=3.

Decomposition:
- Shared package pcs_tx_pkg:
  - XGMII constants: IDLE 0x07, START 0xFB, TERM 0xFD, ERR 0xFE.
  - State enum.
  - gray2bin function, reusable by the write-side logic.
- One natural sub-module: fifo_level_calc (gray-to-binary conversion of both pointers plus subtract), parameterized by ADDRSIZE.

Test Plan:
- Settings for all scenarios: ADDRSIZE=3, START_THRESH=4, MIN_IFG=2, DATA_W=32.
- Reset: assert rrst 2 cycles -> out_data=0x07070707, out_ctrl=0xF, rinc=0, counters 0.
- Threshold: write 3 words -> level=3, rinc stays 0; 4th word -> level=4, STREAM next cycle, rinc high on the following cycle.
- Full frame: 5 words, last with ctrl=0x1 byte0=0xFD, out_ready=1 -> 5 consecutive rinc, outputs match in order, then exactly 2 idle columns, frame_cnt=1.
- Underrun: 6-word frame, only 4 written before empty -> error column 0xFEFEFEFE/0xF, underrun_cnt=1. Remaining 2 words are popped and discarded, no data forwarded, 2 IFG idles, then IDLE; frame_cnt=0.
- Backpressure: out_ready=0 for 3 cycles mid-frame -> rinc=0 and outputs held, then streaming resumes with no lost or duplicated word.
- Wrap: pointers at binary wbin=1, rbin=13 (gray inputs) -> level=4 and the frame starts.
